// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with shared scan/debounce counter and registered decoded outputs.
// Optional KEYPAD_CLICK_EN adds a one-cycle click pulse on every accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       alarm_button,
  output logic       time_button,
  output logic [1:0] dbg_state
`ifdef KEYPAD_CLICK_EN
  ,
  output logic       click
`endif
);

  localparam int unsigned MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int          CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    NOKEY     = 4'hA;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Handshake-free block: row is sampled every cycle, outputs are level-valid registers.
  state_t        state_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    row_idx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    col_q;
  logic [3:0]    key_q;
  logic          alarm_q;
  logic          time_q;
`ifdef KEYPAD_CLICK_EN
  logic          click_q;
`endif

  logic [CW-1:0] cnt_inc_d;
  logic [1:0]    col_idx_nxt_d;
  logic [1:0]    low_row_d;
  logic          row_bit_d;

  function automatic logic [2:0] col_drive(input logic [1:0] c);
    logic [2:0] drv;
    case (c)
      2'd0:    drv = 3'b110;
      2'd1:    drv = 3'b101;
      2'd2:    drv = 3'b011;
      default: drv = 3'b110;
    endcase
    return drv;
  endfunction

  // Returns {key, alarm_button, time_button} for a captured (row, column).
  function automatic logic [5:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] r4;
    logic [3:0] k;
    logic [5:0] res;
    r4  = {2'b00, r};
    k   = r4 + r4 + r4 + {2'b00, c} + 4'd1;
    res = {NOKEY, 1'b0, 1'b0};
    if (r != 2'd3) begin
      res = {k, 1'b0, 1'b0};
    end else begin
      case (c)
        2'd0:    res = {NOKEY, 1'b1, 1'b0};
        2'd1:    res = {4'h0,  1'b0, 1'b0};
        2'd2:    res = {NOKEY, 1'b0, 1'b1};
        default: res = {NOKEY, 1'b0, 1'b0};
      endcase
    end
    return res;
  endfunction

  always_comb begin
    cnt_inc_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    col_idx_nxt_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    row_bit_d     = row[row_idx_q];
    if (!row[0])      low_row_d = 2'd0;
    else if (!row[1]) low_row_d = 2'd1;
    else if (!row[2]) low_row_d = 2'd2;
    else              low_row_d = 2'd3;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
      col_q     <= 3'b110;
      key_q     <= NOKEY;
      alarm_q   <= 1'b0;
      time_q    <= 1'b0;
`ifdef KEYPAD_CLICK_EN
      click_q   <= 1'b0;
`endif
    end else begin
`ifdef KEYPAD_CLICK_EN
      click_q <= 1'b0;
`endif
      case (state_q)
        SCAN: begin
          if (cnt_q >= SCAN_LAST) begin
            cnt_q <= '0;
            if (row == 4'hF) begin
              col_idx_q <= col_idx_nxt_d;
              col_q     <= col_drive(col_idx_nxt_d);
            end else begin
              row_idx_q <= low_row_d;
              state_q   <= DEB_PRESS;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        DEB_PRESS: begin
          if (row_bit_d) begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            state_q <= HELD;
            {key_q, alarm_q, time_q} <= decode(row_idx_q, col_idx_q);
`ifdef KEYPAD_CLICK_EN
            click_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        HELD: begin
          if (row_bit_d) begin
            cnt_q   <= '0;
            state_q <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          // A low bit here is a release bounce: outputs untouched, no new click.
          if (!row_bit_d) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q     <= '0;
            state_q   <= SCAN;
            key_q     <= NOKEY;
            alarm_q   <= 1'b0;
            time_q    <= 1'b0;
            col_idx_q <= col_idx_nxt_d;
            col_q     <= col_drive(col_idx_nxt_d);
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= SCAN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign col          = col_q;
  assign key          = key_q;
  assign alarm_button = alarm_q;
  assign time_button  = time_q;
  assign dbg_state    = state_q;
`ifdef KEYPAD_CLICK_EN
  assign click        = click_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_CYCLES=2, DEBOUNCE_CYCLES=4) driving a pressed-key matrix model.
module tb_keypad_scanner;

  localparam logic [1:0] ST_SCAN = 2'd0, ST_DEBP = 2'd1, ST_HELD = 2'd2, ST_DEBR = 2'd3;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key;
  logic        alarm_button;
  logic        time_button;
  logic [1:0]  dbg_state;
`ifdef KEYPAD_CLICK_EN
  logic        click;
`endif
  logic [11:0] pressed;
  int          total;
  int          bad;

  keypad_scanner #(.SCAN_CYCLES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .row(row),
    .col(col),
    .key(key),
    .alarm_button(alarm_button),
    .time_button(time_button),
    .dbg_state(dbg_state)
`ifdef KEYPAD_CLICK_EN
    ,
    .click(click)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key (r,c) lives at bit r*3+c; a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input int max_cyc);
    for (int i = 0; i < max_cyc && dbg_state != target; i++) tick();
    chk("wait_state", {6'd0, dbg_state}, {6'd0, target});
  endtask

  task automatic chk_click(input string tag, input logic exp);
`ifdef KEYPAD_CLICK_EN
    chk(tag, {7'd0, click}, {7'd0, exp});
`else
    chk(tag, {7'd0, alarm_button & time_button}, {7'd0, 1'b0 & exp});
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    pressed = '0;
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_col", {5'd0, col}, 8'h06);
    chk("rst_key", {4'd0, key}, 8'h0A);
    chk("rst_alarm", {7'd0, alarm_button}, 8'h00);
    chk("rst_time", {7'd0, time_button}, 8'h00);
    chk("rst_state", {6'd0, dbg_state}, {6'd0, ST_SCAN});
    chk_click("rst_click", 1'b0);

    // Idle scan rotation, two cycles per column
    reset = 1'b1;
    tick(); chk("scan_p1", {5'd0, col}, 8'h06);
    tick(); chk("scan_p2", {5'd0, col}, 8'h05);
    tick(); tick(); chk("scan_p4", {5'd0, col}, 8'h03);
    tick(); tick(); chk("scan_p6", {5'd0, col}, 8'h06);

    // Key '5': output 4 cycles after the first low sample
    pressed[4] = 1'b1;
    wait_state(ST_DEBP, 20);
    chk("k5_col", {5'd0, col}, 8'h05);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("k5_pre_key", {4'd0, key}, 8'h0A);
      chk("k5_pre_col", {5'd0, col}, 8'h05);
    end
    tick();
    chk("k5_key", {4'd0, key}, 8'h05);
    chk_click("k5_click", 1'b1);
    tick();
    chk_click("k5_click_off", 1'b0);
    repeat (5) tick();
    chk("k5_hold", {4'd0, key}, 8'h05);
    pressed[4] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("k5_rel_hold", {4'd0, key}, 8'h05);
      chk_click("k5_rel_click", 1'b0);
    end
    tick();
    chk("k5_rel_key", {4'd0, key}, 8'h0A);
    chk("k5_rel_state", {6'd0, dbg_state}, {6'd0, ST_SCAN});
    chk("k5_rel_col", {5'd0, col}, 8'h03);

    // Key '8' with press bounce
    pressed[7] = 1'b1;
    wait_state(ST_DEBP, 20);
    tick();
    chk("k8_b_state", {6'd0, dbg_state}, {6'd0, ST_DEBP});
    pressed[7] = 1'b0;
    tick();
    chk("k8_b_scan", {6'd0, dbg_state}, {6'd0, ST_SCAN});
    chk("k8_b_col", {5'd0, col}, 8'h05);
    chk("k8_b_key", {4'd0, key}, 8'h0A);
    pressed[7] = 1'b1;
    tick();
    chk("k8_rescan", {6'd0, dbg_state}, {6'd0, ST_SCAN});
    tick();
    chk("k8_redeb", {6'd0, dbg_state}, {6'd0, ST_DEBP});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("k8_pre_key", {4'd0, key}, 8'h0A);
    end
    tick();
    chk("k8_key", {4'd0, key}, 8'h08);
    pressed[7] = 1'b0;
    repeat (4) tick();
    chk("k8_rel_hold", {4'd0, key}, 8'h08);
    tick();
    chk("k8_rel_key", {4'd0, key}, 8'h0A);

    // '*' with release glitch
    pressed[9] = 1'b1;
    wait_state(ST_HELD, 40);
    chk("star_alarm", {7'd0, alarm_button}, 8'h01);
    chk("star_key", {4'd0, key}, 8'h0A);
    chk("star_time", {7'd0, time_button}, 8'h00);
    pressed[9] = 1'b0;
    tick();
    chk("star_g0_state", {6'd0, dbg_state}, {6'd0, ST_DEBR});
    chk("star_g0_alarm", {7'd0, alarm_button}, 8'h01);
    tick();
    chk("star_g1_alarm", {7'd0, alarm_button}, 8'h01);
    pressed[9] = 1'b1;
    tick();
    chk("star_back_held", {6'd0, dbg_state}, {6'd0, ST_HELD});
    chk("star_back_alarm", {7'd0, alarm_button}, 8'h01);
    chk_click("star_back_click", 1'b0);
    pressed[9] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("star_rel_alarm", {7'd0, alarm_button}, 8'h01);
      chk("star_rel_key", {4'd0, key}, 8'h0A);
    end
    tick();
    chk("star_drop", {7'd0, alarm_button}, 8'h00);
    chk("star_drop_key", {4'd0, key}, 8'h0A);

    // '#' held, '1' pressed too: no rollover
    pressed[11] = 1'b1;
    wait_state(ST_HELD, 40);
    chk("hash_time", {7'd0, time_button}, 8'h01);
    chk("hash_col", {5'd0, col}, 8'h03);
    pressed[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hash_nr_time", {7'd0, time_button}, 8'h01);
      chk("hash_nr_key", {4'd0, key}, 8'h0A);
      chk("hash_nr_col", {5'd0, col}, 8'h03);
    end
    pressed[11] = 1'b0;
    repeat (4) tick();
    chk("hash_rel_hold", {7'd0, time_button}, 8'h01);
    tick();
    chk("hash_rel_time", {7'd0, time_button}, 8'h00);
    chk("hash_rel_col", {5'd0, col}, 8'h06);
    wait_state(ST_HELD, 20);
    chk("one_key", {4'd0, key}, 8'h01);
    chk("one_time", {7'd0, time_button}, 8'h00);
    pressed[0] = 1'b0;
    wait_state(ST_SCAN, 20);
    chk("one_rel_key", {4'd0, key}, 8'h0A);

    // Reset while '0' is held
    pressed[10] = 1'b1;
    wait_state(ST_HELD, 40);
    chk("zero_key", {4'd0, key}, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("zrst_key", {4'd0, key}, 8'h0A);
    chk("zrst_col", {5'd0, col}, 8'h06);
    chk("zrst_state", {6'd0, dbg_state}, {6'd0, ST_SCAN});
    chk_click("zrst_click", 1'b0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("zre_pre_key", {4'd0, key}, 8'h0A);
      chk_click("zre_pre_click", 1'b0);
    end
    tick();
    chk("zre_key", {4'd0, key}, 8'h00);
    chk("zre_col", {5'd0, col}, 8'h05);
    chk_click("zre_click", 1'b1);
    pressed[10] = 1'b0;
    wait_state(ST_SCAN, 20);
    chk("zre_rel_key", {4'd0, key}, 8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: clock cycles each column is driven before row sampling; legal 2..255.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a press or a release; legal 2..65535.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port row  input  4  keypad row sense lines, active-low, externally pulled up, pre-synchronised.
REQ-006 Port col  output  3  keypad column drive, active-low, one-hot-low while scanning.
REQ-007 Port key  output  4  digit code 0-9 while a digit key is held; 4'hA (NOKEY) otherwise.
REQ-008 Port alarm_button  output  1  high while '*' is held (debounced).
REQ-009 Port time_button  output  1  high while '#' is held (debounced).
REQ-010 Port click  output  1  one-cycle pulse on each accepted press; present only with KEYPAD_CLICK_EN.

Function
REQ-011 Keypad map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = '*',0,'#'.
REQ-012 The FSM SHALL have states SCAN, DEB_PRESS, HELD, DEB_RELEASE.
REQ-013 SCAN: drive col[c] low, all other columns high, for SCAN_CYCLES cycles; sample row on the last cycle; if row==4'hF, advance c (0->1->2->0); otherwise capture the lowest-indexed low row plus c and go to DEB_PRESS.
REQ-014 In DEB_PRESS, HELD and DEB_RELEASE, col SHALL stay frozen on the captured column.
REQ-015 DEB_PRESS: the counter increments each cycle the captured row bit is low; if the bit goes high, clear the counter and return to SCAN on the same column; on count == DEBOUNCE_CYCLES-1, go to HELD.
REQ-016 HELD entry: outputs update on the cycle after the terminal count; key/alarm_button/time_button hold until release is accepted.
REQ-017 HELD: the captured row bit going high clears the counter and moves to DEB_RELEASE.
REQ-018 DEB_RELEASE: the counter increments each cycle the bit is high; the bit going low clears the counter and returns to HELD with no output change; on count == DEBOUNCE_CYCLES-1, the next cycle sets key=4'hA, clears both buttons and enters SCAN on the next column.
REQ-019 Other keys pressed while in HELD SHALL be ignored (no rollover); only the captured key is tracked.
REQ-020 At most one of {key!=4'hA, alarm_button, time_button} SHALL be true at any time.
REQ-021 All outputs SHALL be registered, with no combinational path from row to any output.
REQ-022 The counter SHALL saturate and never wrap; SCAN_CYCLES and DEBOUNCE_CYCLES SHALL share one counter sized for the larger parameter.

Reset
REQ-023 reset low SHALL immediately force: state SCAN, column index 0, col=3'b110, key=4'hA, alarm_button=0, time_button=0, click=0, counter=0.
REQ-024 Reset asserted mid-press SHALL abandon the press with no click; after release, scanning restarts at column 0 and a still-held key needs a full DEBOUNCE_CYCLES again.

Configuration
REQ-025 Macro KEYPAD_CLICK_EN defined: port click exists and pulses high for exactly one cycle, coincident with the first cycle of asserted outputs on entering HELD; there is no pulse on release or on a DEB_RELEASE->HELD bounce.
REQ-026 Macro KEYPAD_CLICK_EN undefined: port click and its logic are absent; all other behaviour is identical.

Verification (SCAN_CYCLES=2, DEBOUNCE_CYCLES=4)
REQ-027 Hold row=4'b1101 while col=3'b101 (key '5') -> key=4'h5 appears 4 cycles after the first low sample and stays while held; click pulses once.
REQ-028 Key '8' bounce: low 2 cycles, high 1, low steady -> no output during the bounce; key=4'h8 only after 4 consecutive low cycles.
REQ-029 Hold '*' then release with a 2-cycle high glitch before the final release -> alarm_button stays high through the glitch and drops 1 cycle after the 4th consecutive high cycle; key stays 4'hA throughout.
REQ-030 '#' held, then '1' also pressed -> time_button stays high, key stays 4'hA, col stays 3'b011 until '#' is released.
REQ-031 Assert reset during HELD of '0' -> key=4'hA, col=3'b110 immediately; after deassert with '0' still held -> key=4'h0 after a full scan and debounce.
REQ-032 Build without KEYPAD_CLICK_EN and rerun REQ-027 -> identical key timing, no click port.
